// File: rtl/reg_file_mp.sv
// Multi-port integer register file: x0 reads as zero, optional same-cycle write
// forwarding, and a post-reset sequencer that zeroes one entry per cycle.
module reg_file_mp #(
    parameter  int REGFILE_COUNT = 32,
    parameter  int WORD_SIZE     = 32,
    parameter  int NUM_READ      = 2,
    parameter  int NUM_WRITE     = 1,
    parameter  int BYPASS        = 1,
    localparam int AW            = $clog2(REGFILE_COUNT)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    output logic                          busy_o,
    input  logic [NUM_WRITE-1:0]          we_i,
    input  logic [NUM_WRITE*AW-1:0]       waddr_i,
    input  logic [NUM_WRITE*WORD_SIZE-1:0] wdata_i,
    input  logic [NUM_READ*AW-1:0]        raddr_i,
    output logic [NUM_READ*WORD_SIZE-1:0] rdata_o
);

    localparam logic [AW:0]   RC_W     = (AW+1)'(REGFILE_COUNT);
    localparam logic [AW-1:0] LAST_IDX = AW'(REGFILE_COUNT - 1);

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [AW-1:0]       r_clr_ptr;
    logic [AW-1:0]       w_clr_ptr_next;
    logic                r_busy;
    logic                w_busy_next;

    // Entry 0 has no storage; it is synthesised as a constant zero on the read side.
    logic [WORD_SIZE-1:0] r_mem [1:REGFILE_COUNT-1];

    logic [AW-1:0]        w_waddr  [NUM_WRITE];
    logic [WORD_SIZE-1:0] w_wdata  [NUM_WRITE];
    logic [NUM_WRITE-1:0] w_wvalid;
    logic                 w_rd_en;

    generate
        for (genvar gi = 0; gi < NUM_WRITE; gi++) begin : g_wport
            assign w_waddr[gi]  = waddr_i[gi*AW +: AW];
            assign w_wdata[gi]  = wdata_i[gi*WORD_SIZE +: WORD_SIZE];
            assign w_wvalid[gi] = we_i[gi] && (w_waddr[gi] != '0)
                                  && ({1'b0, w_waddr[gi]} < RC_W);
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state   <= ST_CLEAR;
            r_clr_ptr <= AW'(1);
            r_busy    <= 1'b1;
        end else begin
            r_state   <= w_state_next;
            r_clr_ptr <= w_clr_ptr_next;
            r_busy    <= w_busy_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_clr_ptr_next = r_clr_ptr;
        w_busy_next    = r_busy;
        case (r_state)
            ST_CLEAR: begin
                w_clr_ptr_next = r_clr_ptr + 1'b1;
                if (r_clr_ptr == LAST_IDX) begin
                    w_state_next = ST_RUN;
                    w_busy_next  = 1'b0;
                end
            end
            ST_RUN: begin
            end
        endcase
    end

    // Ascending port order makes the highest-indexed port's write the one that sticks.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (r_state == ST_CLEAR) begin
                r_mem[r_clr_ptr] <= '0;
            end else begin
                for (int k = 0; k < NUM_WRITE; k++) begin
                    if (w_wvalid[k]) begin
                        r_mem[w_waddr[k]] <= w_wdata[k];
                    end
                end
            end
        end
    end

    assign w_rd_en = !rst_i && !r_busy;
    assign busy_o  = r_busy;

    generate
        for (genvar gi = 0; gi < NUM_READ; gi++) begin : g_rport
            logic [AW-1:0]        w_raddr;
            logic [WORD_SIZE-1:0] w_rdata;

            assign w_raddr = raddr_i[gi*AW +: AW];

            always_comb begin
                w_rdata = '0;
                if (w_rd_en && (w_raddr != '0) && ({1'b0, w_raddr} < RC_W)) begin
                    w_rdata = r_mem[w_raddr];
                    if (BYPASS != 0) begin
                        for (int k = 0; k < NUM_WRITE; k++) begin
                            if (w_wvalid[k] && (w_waddr[k] == w_raddr)) begin
                                w_rdata = w_wdata[k];
                            end
                        end
                    end
                end
            end

            assign rdata_o[gi*WORD_SIZE +: WORD_SIZE] = w_rdata;
        end
    endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two configurations (32 regs with bypass, 24 regs without)
// share one stimulus stream and are checked against an array-based reference model.
module tb_reg_file_mp;

    localparam int AW = 5;
    localparam int W  = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          busy_a, busy_b;
    logic [1:0]    we;
    logic [9:0]    waddr;
    logic [63:0]   wdata;
    logic [9:0]    raddr;
    logic [63:0]   rdata_a, rdata_b;

    always #5 clk = ~clk;

    reg_file_mp #(.REGFILE_COUNT(32), .WORD_SIZE(W), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(1)) dut_a (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_a), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata_a)
    );

    reg_file_mp #(.REGFILE_COUNT(24), .WORD_SIZE(W), .NUM_READ(2), .NUM_WRITE(2), .BYPASS(0)) dut_b (
        .clk_i(clk), .rst_i(rst), .busy_o(busy_b), .we_i(we), .waddr_i(waddr),
        .wdata_i(wdata), .raddr_i(raddr), .rdata_o(rdata_b)
    );

    // Reference model: contents per instance plus remaining clear cycles.
    logic [31:0] ref_mem [2][32];
    int          busy_left [2];
    int          n_cmp  = 0;
    int          n_fail = 0;
    logic        obs_busy_a, obs_busy_b;

    function automatic int rc_of(input int i);
        return (i == 0) ? 32 : 24;
    endfunction

    function automatic logic [31:0] exp_rd(input int i, input int j);
        int          a;
        logic [31:0] v;
        a = int'(raddr[j*AW +: AW]);
        if (rst || busy_left[i] > 0 || a == 0 || a >= rc_of(i)) return '0;
        v = ref_mem[i][a];
        if (i == 0) begin
            for (int k = 0; k < 2; k++)
                if (we[k] && int'(waddr[k*AW +: AW]) == a) v = wdata[k*W +: W];
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic model_edge();
        int a;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                busy_left[i] = rc_of(i) - 1;
                for (int e = 0; e < 32; e++) ref_mem[i][e] = '0;
            end else if (busy_left[i] > 0) begin
                busy_left[i]--;
            end else begin
                for (int k = 0; k < 2; k++) begin
                    a = int'(waddr[k*AW +: AW]);
                    if (we[k] && a != 0 && a < rc_of(i)) ref_mem[i][a] = wdata[k*W +: W];
                end
            end
        end
    endtask

    task automatic settle();
        @(negedge clk);
        obs_busy_a = busy_a;
        obs_busy_b = busy_b;
        chk("busy_a", 32'(busy_a), 32'(busy_left[0] > 0));
        chk("busy_b", 32'(busy_b), 32'(busy_left[1] > 0));
        for (int j = 0; j < 2; j++) begin
            chk($sformatf("rd_a_p%0d@x%0d", j, raddr[j*AW +: AW]), rdata_a[j*W +: W], exp_rd(0, j));
            chk($sformatf("rd_b_p%0d@x%0d", j, raddr[j*AW +: AW]), rdata_b[j*W +: W], exp_rd(1, j));
        end
    endtask

    task automatic adv();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic step();
        settle();
        adv();
    endtask

    task automatic drive(input logic [1:0] w, input logic [4:0] wa0, input logic [31:0] wd0,
                         input logic [4:0] wa1, input logic [31:0] wd1,
                         input logic [4:0] ra0, input logic [4:0] ra1);
        we    = w;
        waddr = {wa1, wa0};
        wdata = {wd1, wd0};
        raddr = {ra1, ra0};
    endtask

    initial begin
        int cnt_a, cnt_b;
        logic [4:0] a0, a1;

        rst = 1'b1;
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        @(posedge clk);
        model_edge();
        #1;
        repeat (2) step();

        // Release reset; writes to x5 during the clear must be ignored.
        rst = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            if (c < 20) drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0, 5'd5, 5'd5);
            else        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd5, 5'd5);
            settle();
            cnt_a += int'(obs_busy_a);
            cnt_b += int'(obs_busy_b);
            adv();
        end
        chk("clear_len_a", 32'(cnt_a), 32'd31);
        chk("clear_len_b", 32'(cnt_b), 32'd23);

        for (int a = 0; a < 32; a++) begin
            drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
            step();
        end

        // Mid-clear reset after x30 holds data.
        drive(2'b01, 5'd30, 32'h30303030, 5'd0, 32'h0, 5'd30, 5'd30);
        step();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd30, 5'd30);
        step();
        rst = 1'b1; step();
        rst = 1'b0; repeat (10) step();
        rst = 1'b1; step();
        rst = 1'b0;
        cnt_a = 0;
        cnt_b = 0;
        for (int c = 0; c < 40; c++) begin
            settle();
            cnt_a += int'(obs_busy_a);
            cnt_b += int'(obs_busy_b);
            adv();
        end
        chk("mid_clear_len_a", 32'(cnt_a), 32'd31);
        chk("mid_clear_len_b", 32'(cnt_b), 32'd23);
        settle();
        chk("x30_after_clear", rdata_a[31:0], 32'h0);
        adv();

        // x0 write dropped, x31 written on port 1.
        drive(2'b11, 5'd0, 32'h12345678, 5'd31, 32'hCAFEF00D, 5'd0, 5'd0);
        settle();
        chk("x0_same_cycle", rdata_a[31:0], 32'h0);
        adv();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd31, 5'd31);
        settle();
        chk("x31_p0", rdata_a[31:0], 32'hCAFEF00D);
        chk("x31_p1", rdata_a[63:32], 32'hCAFEF00D);
        chk("x31_oor_b", rdata_b[31:0], 32'h0);
        adv();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd0, 5'd0);
        settle();
        chk("x0_after", rdata_a[31:0], 32'h0);
        adv();

        // Bypass vs. no bypass on x7.
        drive(2'b01, 5'd7, 32'h77777777, 5'd0, 32'h0, 5'd7, 5'd7);
        step();
        drive(2'b01, 5'd7, 32'hA5A5A5A5, 5'd0, 32'h0, 5'd7, 5'd7);
        settle();
        chk("bypass_a", rdata_a[31:0], 32'hA5A5A5A5);
        chk("nobypass_b", rdata_b[31:0], 32'h77777777);
        adv();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd7, 5'd7);
        settle();
        chk("x7_next_a", rdata_a[31:0], 32'hA5A5A5A5);
        chk("x7_next_b", rdata_b[63:32], 32'hA5A5A5A5);
        adv();

        // Same-address collision: port 1 wins.
        drive(2'b11, 5'd9, 32'h1, 5'd9, 32'h2, 5'd9, 5'd9);
        settle();
        chk("coll_bypass_a", rdata_a[31:0], 32'h2);
        adv();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd9, 5'd9);
        settle();
        chk("coll_stored_a", rdata_a[31:0], 32'h2);
        chk("coll_stored_b", rdata_b[31:0], 32'h2);
        adv();
        drive(2'b11, 5'd3, 32'h3, 5'd4, 32'h4, 5'd3, 5'd4);
        step();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd3, 5'd4);
        settle();
        chk("dual_x3_a", rdata_a[31:0], 32'h3);
        chk("dual_x4_a", rdata_a[63:32], 32'h4);
        chk("dual_x3_b", rdata_b[31:0], 32'h3);
        chk("dual_x4_b", rdata_b[63:32], 32'h4);
        adv();

        // Out-of-range for 24 entries; x23 is the last valid entry there.
        drive(2'b11, 5'd27, 32'hFF, 5'd23, 32'h23, 5'd0, 5'd0);
        step();
        drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0, 5'd27, 5'd23);
        settle();
        chk("x27_a", rdata_a[31:0], 32'hFF);
        chk("x27_oor_b", rdata_b[31:0], 32'h0);
        chk("x23_last_b", rdata_b[63:32], 32'h23);
        adv();

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst = ($urandom_range(0, 99) == 0);
            a0  = 5'($urandom_range(0, 31));
            a1  = ($urandom_range(0, 3) == 0) ? a0 : 5'($urandom_range(0, 31));
            we    = 2'($urandom_range(0, 3));
            waddr = {a1, a0};
            wdata = {$urandom, $urandom};
            raddr[4:0] = ($urandom_range(0, 2) == 0) ? a0 : 5'($urandom_range(0, 31));
            raddr[9:5] = ($urandom_range(0, 2) == 0) ? a1 : 5'($urandom_range(0, 31));
            step();
        end
        rst = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
